// File: rtl/bnn_pkg.sv
// Shared definitions for the sequential BNN classifier: FSM state encoding
// and width helpers used by the top level and the neuron lane.
package bnn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HIDDEN = 2'd1,
    ST_ARGMAX = 2'd2,
    ST_DONE   = 2'd3
  } bnn_state_e;

  // Signed +/-feature sum: one sign bit on top of the worst-case magnitude.
  function automatic int sum_bits(input int feat_cnt, input int feat_bits);
    return feat_bits + $clog2(feat_cnt) + 1;
  endfunction

  // Unsigned class score, counts 0..hidden_cnt.
  function automatic int score_bits(input int hidden_cnt);
    return $clog2(hidden_cnt + 1);
  endfunction

  // Index into n items, never narrower than one bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bnn_neuron_lane.sv
// One binary hidden neuron: signed sum of +/-features selected by a weight
// row, fired when the sum is non-negative (a sum of exactly zero fires).
module bnn_neuron_lane
  import bnn_pkg::*;
#(
  parameter int FEAT_CNT  = 16,
  parameter int FEAT_BITS = 4
) (
  input  logic [FEAT_CNT*FEAT_BITS-1:0] features,
  input  logic [FEAT_CNT-1:0]           weights,
  output logic                          fire
);

  localparam int SUM_W = sum_bits(FEAT_CNT, FEAT_BITS);

  logic signed [SUM_W-1:0] sum;

  // Accumulate each feature with the sign its weight bit selects.
  always_comb begin
    sum = '0;
    for (int f = 0; f < FEAT_CNT; f++) begin
      if (weights[f]) sum = sum + SUM_W'(features[f*FEAT_BITS +: FEAT_BITS]);
      else            sum = sum - SUM_W'(features[f*FEAT_BITS +: FEAT_BITS]);
    end
    fire = ~sum[SUM_W-1];
  end

endmodule

// File: rtl/bnn_seq_classifier.sv
// Sequential BNN classifier: LANES hidden neurons per cycle feed XNOR-popcount
// class scores, then a one-class-per-cycle argmax picks the winner.
// Optional feature macro BNN_SCORE_TAP_EN adds the max_score output.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid holds its data until then, and ready never depends on valid.
module bnn_seq_classifier
  import bnn_pkg::*;
#(
  parameter int FEAT_CNT   = 16,
  parameter int FEAT_BITS  = 4,
  parameter int HIDDEN_CNT = 40,
  parameter int CLASS_CNT  = 10,
  parameter int LANES      = 4,
  parameter logic [HIDDEN_CNT*FEAT_CNT-1:0]  W0 = '0,
  parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] W1 = '0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [FEAT_CNT*FEAT_BITS-1:0]     features,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [idx_bits(CLASS_CNT)-1:0]    prediction
`ifdef BNN_SCORE_TAP_EN
  ,
  output logic [score_bits(HIDDEN_CNT)-1:0] max_score
`endif
);

  localparam int NB    = (HIDDEN_CNT + LANES - 1) / LANES;
  localparam int CNT_W = idx_bits(NB);
  localparam int ROWS  = 2 ** CNT_W;
  localparam int SC_W  = score_bits(HIDDEN_CNT);
  localparam int IDX_W = idx_bits(CLASS_CNT);

  bnn_state_e                    state;
  logic [FEAT_CNT*FEAT_BITS-1:0] feat_q;
  logic [CNT_W-1:0]              chunk_cnt;
  logic [IDX_W-1:0]              cls_cnt;
  logic [SC_W-1:0]               scores [CLASS_CNT];
  logic [SC_W-1:0]               best_score;
  logic [IDX_W-1:0]              best_idx;

  logic [LANES-1:0]                 lane_fire;
  logic [LANES-1:0]                 lane_live;
  logic [LANES-1:0][CLASS_CNT-1:0]  lane_cls;
  logic [SC_W-1:0]                  inc [CLASS_CNT];
  logic                             take;
  logic [SC_W-1:0]                  nxt_score;
  logic [IDX_W-1:0]                 nxt_idx;

  // Per lane, a constant table over chunks holds the W0 row, the W1 column
  // and a live flag; the chunk counter picks the current entry. Padding
  // lanes past HIDDEN_CNT are marked dead and contribute nothing.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [ROWS-1:0][FEAT_CNT-1:0]  rows;
    logic [ROWS-1:0][CLASS_CNT-1:0] cols;
    logic [ROWS-1:0]                live;

    for (genvar k = 0; k < ROWS; k++) begin : g_row
      localparam int H = k * LANES + l;
      if (H < HIDDEN_CNT) begin : g_real
        assign rows[k] = W0[H*FEAT_CNT +: FEAT_CNT];
        assign live[k] = 1'b1;
        for (genvar c = 0; c < CLASS_CNT; c++) begin : g_col
          assign cols[k][c] = W1[c*HIDDEN_CNT + H];
        end
      end else begin : g_pad
        assign rows[k] = '0;
        assign live[k] = 1'b0;
        assign cols[k] = '0;
      end
    end

    bnn_neuron_lane #(
      .FEAT_CNT (FEAT_CNT),
      .FEAT_BITS(FEAT_BITS)
    ) u_lane (
      .features(feat_q),
      .weights (rows[chunk_cnt]),
      .fire    (lane_fire[l])
    );

    assign lane_live[l] = live[chunk_cnt];
    assign lane_cls[l]  = cols[chunk_cnt];
  end

  // Per-class XNOR popcount over the live lanes of the current chunk.
  always_comb begin
    for (int c = 0; c < CLASS_CNT; c++) begin
      inc[c] = '0;
      for (int l = 0; l < LANES; l++) begin
        if (lane_live[l] && (lane_cls[l][c] == lane_fire[l])) inc[c] = inc[c] + SC_W'(1);
      end
    end
  end

  // Argmax step: strict greater-than keeps the lowest index on ties.
  always_comb begin
    take      = scores[cls_cnt] > best_score;
    nxt_score = take ? scores[cls_cnt] : best_score;
    nxt_idx   = take ? cls_cnt : best_idx;
  end

  // Control FSM with registered handshake outputs, scores and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      prediction <= '0;
      feat_q     <= '0;
      chunk_cnt  <= '0;
      cls_cnt    <= '0;
      best_score <= '0;
      best_idx   <= '0;
      for (int c = 0; c < CLASS_CNT; c++) scores[c] <= '0;
`ifdef BNN_SCORE_TAP_EN
      max_score  <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            feat_q    <= features;
            chunk_cnt <= '0;
            for (int c = 0; c < CLASS_CNT; c++) scores[c] <= '0;
            in_ready  <= 1'b0;
            state     <= ST_HIDDEN;
          end else if (!in_ready) begin
            // First IDLE cycle after a result handoff: ready rises one cycle late.
            in_ready <= 1'b1;
          end
        end
        ST_HIDDEN: begin
          for (int c = 0; c < CLASS_CNT; c++) scores[c] <= scores[c] + inc[c];
          if (chunk_cnt == CNT_W'(NB - 1)) begin
            chunk_cnt  <= '0;
            cls_cnt    <= '0;
            best_score <= '0;
            best_idx   <= '0;
            state      <= ST_ARGMAX;
          end else begin
            chunk_cnt <= chunk_cnt + CNT_W'(1);
          end
        end
        ST_ARGMAX: begin
          best_score <= nxt_score;
          best_idx   <= nxt_idx;
          if (cls_cnt == IDX_W'(CLASS_CNT - 1)) begin
            prediction <= nxt_idx;
`ifdef BNN_SCORE_TAP_EN
            max_score  <= nxt_score;
`endif
            out_valid  <= 1'b1;
            state      <= ST_DONE;
          end else begin
            cls_cnt <= cls_cnt + IDX_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_seq_classifier.sv
// Directed bench for bnn_seq_classifier. Four instances share clock, reset and
// input handshakes and are driven in lockstep:
//   dut_a LANES=4, W0 all ones, W1 row 3 all ones   -> always class 3, score 40
//   dut_t LANES=4, random W0, identical W1 rows     -> always class 0 (tie)
//   dut_b LANES=3, random W0/W1                     -> golden model
//   dut_c LANES=40, same weights as dut_b           -> golden model
module tb_bnn_seq_classifier;

  localparam logic [639:0] W0_ONES = {640{1'b1}};
  localparam logic [399:0] W1_ROW3 = {{240{1'b0}}, {40{1'b1}}, {120{1'b0}}};
  localparam logic [639:0] W0_RND  = {4{160'h9E3779B9_7F4A7C15_F39CC060_5CEDC834_1082276B}};
  localparam logic [399:0] W1_TIE  = {10{40'h9A_3C5E_7F12}};
  localparam logic [399:0] W1_RND  = {200'hD1B54A32D192ED03_AEF7C9A1B2C3D4E5_0F1E2D3C4B5A6978_C3,
                                      200'h5851F42D4C957F2D_14057B7EF767814F_9C6B1E0A3D8F2471_6E};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] features = '0;

  logic       rdy_a, rdy_t, rdy_b, rdy_c;
  logic       ov_a, ov_t, ov_b, ov_c;
  logic [3:0] pr_a, pr_t, pr_b, pr_c;
`ifdef BNN_SCORE_TAP_EN
  logic [5:0] ms_a, ms_t, ms_b, ms_c;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bnn_seq_classifier #(.LANES(4), .W0(W0_ONES), .W1(W1_ROW3)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a), .features(features),
    .out_valid(ov_a), .out_ready(out_ready), .prediction(pr_a)
`ifdef BNN_SCORE_TAP_EN
    , .max_score(ms_a)
`endif
  );

  bnn_seq_classifier #(.LANES(4), .W0(W0_RND), .W1(W1_TIE)) dut_t (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_t), .features(features),
    .out_valid(ov_t), .out_ready(out_ready), .prediction(pr_t)
`ifdef BNN_SCORE_TAP_EN
    , .max_score(ms_t)
`endif
  );

  bnn_seq_classifier #(.LANES(3), .W0(W0_RND), .W1(W1_RND)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b), .features(features),
    .out_valid(ov_b), .out_ready(out_ready), .prediction(pr_b)
`ifdef BNN_SCORE_TAP_EN
    , .max_score(ms_b)
`endif
  );

  bnn_seq_classifier #(.LANES(40), .W0(W0_RND), .W1(W1_RND)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_c), .features(features),
    .out_valid(ov_c), .out_ready(out_ready), .prediction(pr_c)
`ifdef BNN_SCORE_TAP_EN
    , .max_score(ms_c)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Golden network: full hidden layer, then popcount scores and argmax.
  function automatic void model(input logic [63:0] f, input logic [639:0] w0,
                                input logic [399:0] w1, output int pred, output int best);
    int s, sc, v;
    logic hid [40];
    for (int h = 0; h < 40; h++) begin
      s = 0;
      for (int i = 0; i < 16; i++) begin
        v = int'(f[i*4 +: 4]);
        s = w0[h*16 + i] ? s + v : s - v;
      end
      hid[h] = (s >= 0);
    end
    pred = 0;
    best = -1;
    for (int c = 0; c < 10; c++) begin
      sc = 0;
      for (int h = 0; h < 40; h++) if (w1[c*40 + h] == hid[h]) sc++;
      if (sc > best) begin
        best = sc;
        pred = c;
      end
    end
  endfunction

  // Wait for every instance to be ready, then present one vector for one edge.
  task automatic do_send(input logic [63:0] f);
    int n = 0;
    @(negedge clk);
    while (!(rdy_a && rdy_t && rdy_b && rdy_c) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 32'(n < 200), 32'd1);
    features = f;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Wait for every result, stall a random time, check, then accept.
  task automatic do_recv(input logic [63:0] f, input int stall);
    int n = 0;
    int mp, mb;
    @(negedge clk);
    while (!(ov_a && ov_t && ov_b && ov_c) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_wait", 32'(n < 200), 32'd1);
    repeat (stall) @(negedge clk);
    model(f, W0_RND, W1_RND, mp, mb);
    chk("pred_a", 32'(pr_a), 32'd3);
    chk("pred_tie", 32'(pr_t), 32'd0);
    chk("pred_b", 32'(pr_b), 32'(mp));
    chk("pred_c", 32'(pr_c), 32'(mp));
`ifdef BNN_SCORE_TAP_EN
    chk("score_a", 32'(ms_a), 32'd40);
    chk("score_b", 32'(ms_b), 32'(mb));
    chk("score_c", 32'(ms_c), 32'(mb));
`endif
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    logic v;
    logic [63:0] f;

    // Reset values, during and after reset, with in_valid low.
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(rdy_a), 32'd1);
    chk("rst_out_valid", 32'(ov_a), 32'd0);
    chk("rst_pred", 32'(pr_a), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_in_ready", 32'({rdy_a, rdy_c}), 32'd3);
      chk("idle_out_valid", 32'({ov_a, ov_c}), 32'd0);
      chk("idle_pred", 32'({pr_a, pr_c}), 32'd0);
    end

    // Zero features: every hidden neuron fires, class 3 scores 40.
    // Output must be sampled valid at the 21st edge after the handshake edge.
    do_send(64'h0);
    cyc = 0;
    v = 1'b0;
    while (!v && cyc < 100) begin
      @(negedge clk);
      v = ov_a;
      @(posedge clk);
      cyc++;
    end
    chk("latency", 32'(cyc), 32'd21);
    do_recv(64'h0, 0);

    // Result held in DONE for 5 cycles; an in_valid pulse there is ignored.
    f = 64'h0123_4567_89AB_CDEF;
    do_send(f);
    cyc = 0;
    @(negedge clk);
    while (!(ov_a && ov_t && ov_b && ov_c) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_wait", 32'(cyc < 200), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_out_valid", 32'(ov_a), 32'd1);
      chk("hold_pred", 32'(pr_a), 32'd3);
      chk("hold_in_ready", 32'({rdy_a, rdy_b}), 32'd0);
      in_valid = (i == 2);
      @(negedge clk);
    end
    in_valid = 1'b0;
    do_recv(f, 0);
    @(negedge clk);
    chk("post_out_valid", 32'({ov_a, ov_b}), 32'd0);
    chk("post_in_ready_low", 32'(rdy_a), 32'd0);
    @(negedge clk);
    chk("post_in_ready_high", 32'(rdy_a), 32'd1);
    repeat (30) @(negedge clk);
    chk("pulse_ignored", 32'({ov_a, ov_t, ov_b, ov_c}), 32'd0);

    // Reset during the fourth HIDDEN cycle aborts immediately.
    do_send(64'hFEDC_BA98_7654_3210);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'({ov_a, ov_b, ov_c}), 32'd0);
    chk("abort_in_ready", 32'({rdy_a, rdy_b, rdy_c}), 32'd7);
    chk("abort_pred", 32'(pr_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    f = 64'hFEDC_BA98_7654_3210;
    do_send(f);
    do_recv(f, 1);

    // Random vectors with random stalls on both sides.
    for (int t = 0; t < 150; t++) begin
      f = {$urandom(), $urandom()};
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_send(f);
      do_recv(f, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
